// File: rtl/seq_div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_div_pkg;

  // Divisor / quotient / remainder width; the dividend is twice this.
  localparam int DIV_W = 8;

  // One quotient bit per RUN cycle.
  localparam int DIV_ITER = 8;

  // Iteration counter width (counts 0..DIV_ITER-1).
  localparam int DIV_CNT_W = 3;

  // Quotient reported on overflow or divide by zero.
  localparam logic [DIV_W-1:0] DIV_Q_OVF = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // The quotient fits in DIV_W bits only if the upper dividend half is
  // strictly below the divisor; a zero divisor always trips this.
  function automatic logic div_overflows(input logic [DIV_W-1:0] hi,
                                         input logic [DIV_W-1:0] dv);
    return (hi >= dv);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit and
// subtract the divisor if it fits.
module div_step
  import seq_div_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic [W-1:0] p,
  input  logic         msb_in,
  input  logic [W-1:0] dv,
  output logic [W-1:0] p_next,
  output logic         q_bit
);

  logic [W:0] t;
  logic [W:0] diff;
  logic       borrow;

  // Trial subtract at W+1 bits; the borrow-out picks restore vs keep.
  always_comb begin
    t              = {p, msb_in};
    {borrow, diff} = {1'b0, t} - {2'b00, dv};
    q_bit          = ~borrow;
    // Partial remainder stays below the divisor, so t - dv fits in W bits.
    p_next         = borrow ? t[W-1:0] : W'(diff);
  end

endmodule

// File: rtl/seq_div.sv
// Sequential restoring divider: 2W-bit dividend by W-bit divisor, one
// quotient bit per clock, constant latency of DIV_ITER cycles.
module seq_div
  import seq_div_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  output logic           busy,
  output logic           ready,
  output logic [W-1:0]   q,
  output logic [W-1:0]   r,
  output logic           ovf
);

  div_state_t           state_q;
  logic [DIV_CNT_W-1:0] cnt_q;

  // Working registers: partial remainder, dividend/quotient shifter, divisor.
  logic [W-1:0]         p_q;
  logic [W-1:0]         d_q;
  logic [W-1:0]         dv_q;
  logic                 ov_q;

  // Result registers, updated only on the edge entering DONE.
  logic [W-1:0]         q_q;
  logic [W-1:0]         r_q;
  logic                 ovf_q;

  // Next values of the working registers for the current iteration.
  logic [W-1:0]         p_d;
  logic                 qbit_d;
  logic [W-1:0]         d_d;

  div_step #(.W(W)) u_step (
    .p      (p_q),
    .msb_in (d_q[W-1]),
    .dv     (dv_q),
    .p_next (p_d),
    .q_bit  (qbit_d)
  );

  // Dividend bits shift out the top while quotient bits shift in the bottom.
  always_comb begin
    d_d = {d_q[W-2:0], qbit_d};
  end

  // Control FSM, counter, operand load, iteration and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      d_q     <= '0;
      dv_q    <= '0;
      ov_q    <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            p_q     <= dividend[2*W-1:W];
            d_q     <= dividend[W-1:0];
            dv_q    <= divisor;
            ov_q    <= div_overflows(dividend[2*W-1:W], divisor);
            cnt_q   <= '0;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          p_q   <= p_d;
          d_q   <= d_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == DIV_CNT_W'(DIV_ITER - 1)) begin
            state_q <= DONE;
            // Overflow still runs all iterations so latency never varies.
            if (ov_q) begin
              q_q   <= DIV_Q_OVF;
              r_q   <= '0;
              ovf_q <= 1'b1;
            end else begin
              q_q   <= d_d;
              r_q   <= p_d;
              ovf_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Handshake outputs decode only from registered state.
  always_comb begin
    busy  = (state_q == RUN);
    ready = (state_q == DONE);
  end

  assign q   = q_q;
  assign r   = r_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div against an arithmetic reference model.
module tb_seq_div;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        busy;
  logic        ready;
  logic [7:0]  q;
  logic [7:0]  r;
  logic        ovf;

  int n_chk;
  int n_pass;

  seq_div #(.W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .ready    (ready),
    .q        (q),
    .r        (r),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: plain integer division with the 8-bit quotient limit.
  task automatic model(input logic [15:0] a, input logic [7:0] b,
                       output logic [7:0] eq, output logic [7:0] er, output logic eo);
    int unsigned qq;
    if (b == 0) begin
      eq = 8'hFF; er = 8'h00; eo = 1'b1;
    end else begin
      qq = 32'(a) / 32'(b);
      if (qq > 255) begin
        eq = 8'hFF; er = 8'h00; eo = 1'b1;
      end else begin
        eq = 8'(qq); er = 8'(32'(a) % 32'(b)); eo = 1'b0;
      end
    end
  endtask

  // One operation from an idle DUT; optionally pokes start mid-RUN.
  task automatic run_op(input logic [15:0] a, input logic [7:0] b, input bit poke);
    logic [7:0] eq, er;
    logic       eo;
    int lat, busy_cnt;
    model(a, b, eq, er, eo);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
    dividend = 16'($urandom); divisor = 8'($urandom);
    lat = 0;
    busy_cnt = busy ? 1 : 0;
    while (!ready && lat < 20) begin
      if (poke && lat == 3) begin
        start = 1'b1; dividend = 16'($urandom); divisor = 8'($urandom);
      end
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
      if (busy) busy_cnt++;
    end
    check("latency", lat, 8);
    check("busy_cycles", busy_cnt, 8);
    check("q", q, eq);
    check("r", r, er);
    check("ovf", ovf, eo);
    @(posedge clk); #1;
    check("ready_pulse", ready, 0);
    check("q_hold", q, eq);
  endtask

  initial begin
    logic [15:0] bb_a [3];
    logic [7:0]  bb_b [3];
    logic [7:0]  eq, er;
    logic        eo;
    int          cyc, seen;
    int          blist [7];
    n_chk = 0; n_pass = 0;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    blist = '{1, 2, 3, 7, 85, 128, 255};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_ready", ready, 0);
    check("rst_q", q, 0);
    check("rst_r", r, 0);
    check("rst_ovf", ovf, 0);

    // Directed cases, including the overflow and divide-by-zero corners.
    run_op(16'h1234, 8'h56, 0);
    check("q_1234_56", q, 8'h36);
    check("r_1234_56", r, 8'h10);
    run_op(16'hFEFF, 8'hFF, 0);
    check("q_FEFF_FF", q, 8'hFF);
    check("r_FEFF_FF", r, 8'hFE);
    run_op(16'h00FF, 8'h01, 0);
    check("q_00FF_01", q, 8'hFF);
    check("r_00FF_01", r, 8'h00);
    run_op(16'hABCD, 8'h00, 0);
    check("ovf_div0", ovf, 1);
    run_op(16'h5600, 8'h56, 0);
    check("ovf_5600_56", ovf, 1);
    check("q_5600_56", q, 8'hFF);
    run_op(16'h1234, 8'h56, 1);
    check("q_poked", q, 8'h36);

    // start held high across three back-to-back operations.
    bb_a = '{16'h1234, 16'h5600, 16'h7FFF};
    bb_b = '{8'h56, 8'h56, 8'h81};
    start = 1'b1; dividend = bb_a[0]; divisor = bb_b[0];
    @(posedge clk); #1;
    dividend = bb_a[1]; divisor = bb_b[1];
    cyc = 0;
    for (int k = 0; k < 3; k++) begin
      while (!ready && cyc < 20) begin
        @(posedge clk); #1;
        cyc++;
      end
      check("b2b_spacing", cyc, (k == 0) ? 8 : 9);
      model(bb_a[k], bb_b[k], eq, er, eo);
      check("b2b_q", q, eq);
      check("b2b_r", r, er);
      check("b2b_ovf", ovf, eo);
      if (k == 2) start = 1'b0;
      @(posedge clk); #1;
      check("b2b_ready_low", ready, 0);
      cyc = 1;
      if (k == 0) begin dividend = bb_a[2]; divisor = bb_b[2]; end
    end

    // Reset in the middle of RUN discards the operation.
    start = 1'b1; dividend = 16'h1234; divisor = 8'h56;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_ready", ready, 0);
    check("midrst_q", q, 0);
    check("midrst_r", r, 0);
    check("midrst_ovf", ovf, 0);
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (ready || busy) seen++;
    end
    check("midrst_quiet", seen, 0);
    run_op(16'h0C35, 8'h25, 0);

    // Round-trip sweep: (a*b)/b must give back a with zero remainder.
    foreach (blist[i]) begin
      for (int a = 0; a < 256; a++) begin
        run_op(16'(a * blist[i]), 8'(blist[i]), 0);
        check("rt_q", q, 32'(a));
        check("rt_r", r, 0);
      end
    end

    // Random operands, with occasional zero divisors and mid-RUN pokes.
    for (int n = 0; n < 300; n++) begin
      logic [7:0] b;
      b = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
      run_op(16'($urandom), b, bit'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/seq_div.md
# seq_div

Sequential restoring divider: 16-bit dividend by 8-bit divisor, producing an 8-bit quotient and an 8-bit remainder, one quotient bit per clock. It is the inverse of the team's 8x8 shift-add multiplier. For any `m = a*b` with `b != 0`, it returns `q = a`, `r = 0`. It sits beside the multiplier in the arithmetic lab datapath and uses the same start/ready pulse handshake.

## Interface
- `W`, 8 — divisor, quotient and remainder width; dividend is `2*W`. Only `W = 8` is verified.
- `clk`  in  1  — single clock; all state changes on rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `start`  in  1  — request; sampled on rising edge only when `busy = 0`.
- `dividend`  in  16  — sampled at the accepting edge.
- `divisor`  in  8  — sampled at the accepting edge.
- `busy`  out  1  — high while the state is RUN.
- `ready`  out  1  — one-cycle pulse; `q`, `r` and `ovf` are valid from this cycle onward.
- `q`  out  8  — quotient; holds its value until the next result.
- `r`  out  8  — remainder; holds its value until the next result.
- `ovf`  out  1  — quotient does not fit in 8 bits, or divide by zero.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: if `start`, go to RUN. Otherwise stay.
- RUN: runs for exactly 8 cycles, counted by a 3-bit counter `cnt` (0..7). After the `cnt = 7` iteration, go to DONE.
- DONE: lasts one cycle. If `start`, go to RUN (back-to-back accepted). Otherwise go to IDLE.
- `start` during RUN is ignored. Operands are not re-sampled during RUN.
- Load at the accepting edge:
  - `p[7:0] <= dividend[15:8]` (partial remainder)
  - `d[7:0] <= dividend[7:0]`
  - `dv <= divisor`
  - `ov_r <= (dividend[15:8] >= divisor)`; this is true for `divisor = 0`.
  - `cnt <= 0`
- Iteration (one per RUN cycle):
  - `t[8:0] = {p, d[7]}`.
  - If `t >= {1'b0, dv}`: `p <= t - dv` (fits in 8 bits), quotient bit = 1. Else: `p <= t[7:0]`, bit = 0.
  - `d <= {d[6:0], bit}`.
  - The subtract is computed at 9 bits; its borrow-out selects restore vs keep.
- Edge that enters DONE:
  - Normal case: `q <= d`, `r <= p`, `ovf <= 0`.
  - If `ov_r`: `q <= 8'hFF`, `r <= 8'h00`, `ovf <= 1`.
  - Overflow cases still take the full 8 RUN cycles, so latency is constant.
- Outputs `q`, `r`, `ovf` are dedicated registers, separate from the `p`/`d` working registers. They change only on the edge entering DONE, or on reset.
- Reset (any cycle, including mid-RUN):
  - state = IDLE, `cnt = 0`, `busy = 0`, `ready = 0`, `q = 0`, `r = 0`, `ovf = 0`.
  - The working registers are cleared.
  - An in-flight operation is discarded with no `ready` pulse.
- `rst` and `start` high on the same edge: reset wins.

## Timing
- Accepting edge E0: `start = 1` sampled with state IDLE or DONE.
- Iterations occur at edges E1..E8. State enters DONE at E8.
- `busy = 1` from after E0 until E8.
- `ready = 1` from after E8 until E9. Latency is 8 cycles from the accepting edge to `ready`.
- Throughput with `start` held high: one result every 9 cycles. `ready` pulses once per result.
- `busy` and `ready` decode from registered state only; there is no combinational path from any input to any output.

## Structure
- Package `seq_div_pkg`:
  - state enum `div_state_t` {IDLE, RUN, DONE}
  - `DIV_W = 8`
  - `DIV_ITER = 8`
  - overflow quotient constant `DIV_Q_OVF = 8'hFF`
- Sub-module `div_step` (combinational):
  - inputs `p`, `msb_in`, `dv`
  - outputs `p_next`, `q_bit`
  - performs one restoring step
- The top holds the FSM, counter, working registers and output registers.

## Test plan
- `dividend = 16'h1234`, `divisor = 8'h56` → `ready` exactly 8 cycles after accept, `q = 8'h36`, `r = 8'h10`, `ovf = 0`; `busy` high for exactly 8 cycles.
- `16'hFEFF / 8'hFF` → `q = 8'hFF`, `r = 8'hFE`. `16'h00FF / 8'h01` → `q = 8'hFF`, `r = 8'h00`.
- `divisor = 0` (any dividend), and `16'h5600 / 8'h56` → `ovf = 1`, `q = 8'hFF`, `r = 8'h00`, same 8-cycle latency.
- `start` held high over three operations → `ready` pulses 9 cycles apart with correct `q`/`r` each. A `start` pulse with new operands mid-RUN does not alter the result in progress.
- `rst` asserted at RUN cycle 4 → next edge: IDLE, all outputs 0, no `ready`. A new `start` afterwards completes normally.
- Round-trip sweep: all `a`, with `b` in {1, 2, 3, 7, 85, 128, 255}; `dividend = a*b`, `divisor = b` → `q = a`, `r = 0`, `ovf = 0`.
